// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU instruction fetch path.
// Pairs are two consecutive 32-bit words fetched from an 8-byte aligned local-store address.
package spu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 11;
  localparam int unsigned LS_PC_W = 18;

  localparam logic [OPC_W-1:0] OPC_STOP = 11'h000;

  typedef enum logic [0:0] {
    StFetch,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [1:0]         slot_vld;
    logic [INSTR_W-1:0] instr0;
    logic [INSTR_W-1:0] instr1;
    logic [LS_PC_W-1:0] pc;
  } pair_t;

  function automatic logic [OPC_W-1:0] opc_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/spu_fetch_buffer_if.sv
// Local-store fetch port, decoder port and branch redirect of the SPU fetch buffer.
// master: the fetch buffer itself; slave: local store, decoder and execute.
interface spu_fetch_buffer_if
  import spu_pkg::*;
#(
  parameter int unsigned PC_W = 18
) ();

  logic                 ls_req_valid;
  logic                 ls_req_ready;
  logic [PC_W-1:0]      ls_req_addr;
  logic                 ls_rsp_valid;
  logic [2*INSTR_W-1:0] ls_rsp_data;

  logic                 flush;
  logic [PC_W-1:0]      flush_pc;

  logic                 dec_ready;
  logic                 dec_valid;
  logic [1:0]           dec_slot_vld;
  logic [INSTR_W-1:0]   dec_instr0;
  logic [INSTR_W-1:0]   dec_instr1;
  logic [OPC_W-1:0]     dec_opc0;
  logic [OPC_W-1:0]     dec_opc1;
  logic [PC_W-1:0]      dec_pc;
  logic                 halted;

  modport master (
    output ls_req_valid, ls_req_addr,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  flush, flush_pc,
    input  dec_ready,
    output dec_valid, dec_slot_vld, dec_instr0, dec_instr1, dec_opc0, dec_opc1, dec_pc,
    output halted
  );

  modport slave (
    input  ls_req_valid, ls_req_addr,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output flush, flush_pc,
    output dec_ready,
    input  dec_valid, dec_slot_vld, dec_instr0, dec_instr1, dec_opc0, dec_opc1, dec_pc,
    input  halted
  );

endinterface

// File: rtl/spu_fifo.sv
// Synchronous show-ahead FIFO with synchronous clear; the head entry is read straight
// from the storage registers so it is valid the cycle after it is written.
module spu_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign pop_en  = pop_i && (count_q != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_en = push_i && ((count_q != CntW'(Depth)) || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_en && !pop_en) begin
      count_d = count_q + CntW'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - CntW'(1);
    end
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/spu_fetch_buffer.sv
// SPU instruction fetch and prefetch queue: issues pair fetches against a credit limit,
// discards stale responses after a redirect or stop, and presents pairs to the decoder.
module spu_fetch_buffer
  import spu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     PC_W     = LS_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  spu_fetch_buffer_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic            odd_tgt_q, odd_tgt_d;

  logic [CntW-1:0]    fifo_count;
  logic [CntW:0]      in_use;
  logic               req_valid, req_fire;
  logic               rsp_keep, rsp_stop, stop0;
  logic [INSTR_W-1:0] rsp_w0, rsp_w1;
  logic [PC_W-1:0]    redirect_pc;
  pair_t              push_pair, head_pair;
  logic               head_valid;
  logic               unused_flush_pc_lsbs;

  assign rsp_w0      = bus.ls_rsp_data[2*INSTR_W-1:INSTR_W];
  assign rsp_w1      = bus.ls_rsp_data[INSTR_W-1:0];
  assign redirect_pc = {bus.flush_pc[PC_W-1:3], 3'b000};

  assign unused_flush_pc_lsbs = ^bus.flush_pc[1:0];

  // Queued pairs plus fetches in flight may never exceed the FIFO capacity.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_valid = !reset && (state_q == StFetch) && !bus.flush &&
                     (in_use < (CntW + 1)'(DEPTH));
  assign req_fire  = req_valid && bus.ls_req_ready;
  assign rsp_keep  = bus.ls_rsp_valid && (drop_cnt_q == '0) && (state_q == StFetch) &&
                     !bus.flush;

  always_comb begin
    push_pair          = '0;
    stop0              = !odd_tgt_q && (opc_of(rsp_w0) == OPC_STOP);
    push_pair.slot_vld = {!odd_tgt_q, !stop0};
    push_pair.instr0   = rsp_w0;
    push_pair.instr1   = rsp_w1;
    push_pair.pc       = LS_PC_W'(rsp_pc_q);
    rsp_stop           = stop0 || (push_pair.slot_vld[0] && (opc_of(rsp_w1) == OPC_STOP));
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    odd_tgt_d     = odd_tgt_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q;

    if (req_fire) begin
      outstanding_d = outstanding_d + CntW'(1);
      fetch_pc_d    = fetch_pc_q + PC_W'(8);
    end
    if (bus.ls_rsp_valid && (outstanding_q != '0)) outstanding_d = outstanding_d - CntW'(1);
    if (bus.ls_rsp_valid && (drop_cnt_q != '0))    drop_cnt_d    = drop_cnt_q - CntW'(1);

    if (rsp_keep) begin
      rsp_pc_d  = rsp_pc_q + PC_W'(8);
      odd_tgt_d = 1'b0;
      if (rsp_stop) begin
        state_d    = StHalt;
        drop_cnt_d = outstanding_d;
      end
    end

    if (bus.flush) begin
      state_d    = StFetch;
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      odd_tgt_d  = bus.flush_pc[2];
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StFetch;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      odd_tgt_q     <= 1'b0;
      drop_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      odd_tgt_q     <= odd_tgt_d;
      drop_cnt_q    <= drop_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  spu_fifo #(
    .Depth(DEPTH),
    .Width($bits(pair_t))
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (bus.flush),
    .push_i (rsp_keep),
    .data_i (push_pair),
    .pop_i  (bus.dec_ready),
    .data_o (head_pair),
    .valid_o(head_valid),
    .count_o(fifo_count)
  );

  assign bus.ls_req_valid = req_valid;
  assign bus.ls_req_addr  = fetch_pc_q;
  assign bus.halted       = (state_q == StHalt);

  // Decoder outputs read as zero whenever no pair is presented.
  assign bus.dec_valid    = head_valid;
  assign bus.dec_slot_vld = head_valid ? head_pair.slot_vld : 2'b00;
  assign bus.dec_instr0   = head_valid ? head_pair.instr0 : '0;
  assign bus.dec_instr1   = head_valid ? head_pair.instr1 : '0;
  assign bus.dec_opc0     = head_valid ? opc_of(head_pair.instr0) : '0;
  assign bus.dec_opc1     = head_valid ? opc_of(head_pair.instr1) : '0;
  assign bus.dec_pc       = head_valid ? PC_W'(head_pair.pc) : '0;

endmodule

// File: tb/tb_spu_fetch_buffer.sv
// Randomized bench for spu_fetch_buffer: a local-store responder and a decoder sink drive
// the DUT while a queue-based model of fetched pairs and in-flight fetches predicts outputs.
module tb_spu_fetch_buffer;
  import spu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spu_fetch_buffer_if #(.PC_W(PC_W)) bus ();

  spu_fetch_buffer #(
    .DEPTH   (DEPTH),
    .PC_W    (PC_W),
    .RESET_PC('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [1:0]      sv;
    logic [31:0]     i0;
    logic [31:0]     i1;
  } exp_pair_t;

  typedef struct {
    logic [PC_W-1:0] addr;
    bit              drop;
    bit              odd;
  } fly_t;

  exp_pair_t       m_q[$];
  fly_t            m_fly[$];
  logic [PC_W-1:0] m_addr;
  bit              m_halt;
  bit              m_next_odd;

  int ls_pend[$];
  int cyc;
  int n_total;
  int n_bad;
  int n_fire;

  int p_ready, p_dec, p_flush, p_stop0, p_stop1, d_min, d_max, p_rsp;
  bit              force_flush;
  logic [PC_W-1:0] force_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_fly.delete();
    ls_pend.delete();
    m_addr     = '0;
    m_halt     = 1'b0;
    m_next_odd = 1'b0;
  endtask

  function automatic bit pred_req();
    return !m_halt && !bus.flush && ((m_q.size() + m_fly.size()) < DEPTH);
  endfunction

  task automatic drive();
    logic [31:0] w0, w1;
    bus.ls_req_ready = ($urandom_range(99) < p_ready);
    bus.dec_ready    = ($urandom_range(99) < p_dec);
    bus.flush        = force_flush || ($urandom_range(999) < p_flush);
    bus.flush_pc     = force_flush ? force_pc : (PC_W'($urandom) & 18'h3fffc);
    bus.ls_rsp_valid = 1'b0;
    bus.ls_rsp_data  = '0;
    if (ls_pend.size() > 0 && ls_pend[0] <= cyc && $urandom_range(99) < p_rsp) begin
      w0 = $urandom;
      w1 = $urandom;
      if ($urandom_range(99) < p_stop0) w0[31:21] = 11'h000;
      if ($urandom_range(99) < p_stop1) w1[31:21] = 11'h000;
      bus.ls_rsp_valid = 1'b1;
      bus.ls_rsp_data  = {w0, w1};
    end
  endtask

  task automatic check_outputs(input bit exp_req);
    check("req_valid", 64'(bus.ls_req_valid), 64'(exp_req));
    if (exp_req) check("req_addr", 64'(bus.ls_req_addr), 64'(m_addr));
    check("halted", 64'(bus.halted), 64'(m_halt));
    check("dec_valid", 64'(bus.dec_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("dec_pc", 64'(bus.dec_pc), 64'(m_q[0].pc));
      check("slot_vld", 64'(bus.dec_slot_vld), 64'(m_q[0].sv));
      if (m_q[0].sv[1]) begin
        check("instr0", 64'(bus.dec_instr0), 64'(m_q[0].i0));
        check("opc0", 64'(bus.dec_opc0), 64'(m_q[0].i0[31:21]));
      end
      if (m_q[0].sv[0]) begin
        check("instr1", 64'(bus.dec_instr1), 64'(m_q[0].i1));
        check("opc1", 64'(bus.dec_opc1), 64'(m_q[0].i1[31:21]));
      end
    end
  endtask

  // Advance the model by one clock using the inputs that were held across the edge.
  task automatic model_step(input bit exp_req);
    bit        stop;
    fly_t      f;
    exp_pair_t p;
    stop = 1'b0;
    if (m_q.size() > 0 && bus.dec_ready) void'(m_q.pop_front());
    if (bus.ls_rsp_valid && m_fly.size() > 0) begin
      f = m_fly.pop_front();
      if (!f.drop && !bus.flush) begin
        p.pc = f.addr;
        p.i0 = bus.ls_rsp_data[63:32];
        p.i1 = bus.ls_rsp_data[31:0];
        p.sv[1] = !f.odd;
        p.sv[0] = !(p.sv[1] && p.i0[31:21] == 11'h000);
        stop = !p.sv[0] || (p.i1[31:21] == 11'h000);
        m_q.push_back(p);
      end
    end
    if (exp_req && bus.ls_req_ready) begin
      m_fly.push_back('{addr: m_addr, drop: 1'b0, odd: m_next_odd});
      m_next_odd = 1'b0;
      m_addr     = m_addr + 18'd8;
    end
    if (stop) begin
      m_halt = 1'b1;
      foreach (m_fly[i]) m_fly[i].drop = 1'b1;
    end
    if (bus.flush) begin
      m_q.delete();
      foreach (m_fly[i]) m_fly[i].drop = 1'b1;
      m_halt     = 1'b0;
      m_addr     = {bus.flush_pc[PC_W-1:3], 3'b000};
      m_next_odd = bus.flush_pc[2];
    end
  endtask

  task automatic tick();
    bit exp_req, req_obs;
    drive();
    #1;
    exp_req = pred_req();
    check_outputs(exp_req);
    req_obs = bus.ls_req_valid && bus.ls_req_ready;
    @(posedge clk);
    cyc++;
    model_step(exp_req);
    if (bus.ls_rsp_valid) void'(ls_pend.pop_front());
    if (req_obs) begin
      n_fire++;
      ls_pend.push_back(cyc + $urandom_range(d_max, d_min) - 1);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int rdy, input int dec, input int fl, input int st0,
                     input int st1, input int dmin, input int dmax, input int rsp);
    p_ready = rdy; p_dec = dec; p_flush = fl; p_stop0 = st0; p_stop1 = st1;
    d_min = dmin; d_max = dmax; p_rsp = rsp;
    repeat (n) tick();
  endtask

  task automatic do_flush(input logic [PC_W-1:0] pc);
    force_flush = 1'b1;
    force_pc    = pc;
    tick();
    force_flush = 1'b0;
  endtask

  task automatic check_reset_zeros(input string tag);
    check({tag, "_req_valid"}, 64'(bus.ls_req_valid), 64'd0);
    check({tag, "_dec_valid"}, 64'(bus.dec_valid), 64'd0);
    check({tag, "_halted"}, 64'(bus.halted), 64'd0);
    check({tag, "_slot_vld"}, 64'(bus.dec_slot_vld), 64'd0);
    check({tag, "_dec_pc"}, 64'(bus.dec_pc), 64'd0);
    check({tag, "_instrs"}, {bus.dec_instr0, bus.dec_instr1}, 64'd0);
    check({tag, "_opcs"}, 64'({bus.dec_opc0, bus.dec_opc1}), 64'd0);
  endtask

  // Reset is raised between clock edges to exercise the asynchronous path.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    bus.ls_rsp_valid = 1'b0;
    bus.flush        = 1'b0;
    #1;
    check_reset_zeros("mid_reset");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_total = 0; n_bad = 0; n_fire = 0; cyc = 0;
    force_flush = 1'b0; force_pc = '0;
    bus.ls_req_ready = 1'b0; bus.ls_rsp_valid = 1'b0; bus.ls_rsp_data = '0;
    bus.flush = 1'b0; bus.flush_pc = '0; bus.dec_ready = 1'b0;
    model_clear();
    #1;
    check_reset_zeros("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Streaming: every request accepted, one-cycle return, decoder always ready.
    run(40, 100, 100, 0, 0, 0, 1, 1, 100);

    // Decoder stalled: credits stop fetching at exactly DEPTH pairs.
    do_reset();
    n_fire = 0;
    run(30, 100, 0, 0, 0, 0, 1, 1, 100);
    check("fill_count", 64'(n_fire), 64'(DEPTH));
    run(20, 100, 100, 0, 0, 0, 1, 1, 100);

    // Redirect to an odd word with three fetches in flight.
    do_reset();
    run(6, 100, 100, 0, 0, 0, 3, 3, 100);
    do_flush(18'h124);
    run(20, 100, 100, 0, 0, 0, 3, 3, 100);

    // Stop in slot0 halts fetch; redirect resumes it.
    do_reset();
    run(3, 100, 100, 0, 100, 0, 2, 2, 100);
    run(12, 100, 100, 0, 0, 0, 2, 2, 100);
    do_flush(18'h40);
    run(12, 100, 100, 0, 0, 0, 1, 2, 100);

    // Redirect near the top of local store so the fetch address wraps.
    do_flush(18'h3fff4);
    run(10, 100, 100, 0, 0, 0, 1, 1, 100);

    // Frequent flushes colliding with responses and dequeues.
    run(400, 90, 80, 150, 5, 5, 1, 2, 90);

    // Long mixed traffic, then reset in the middle of a burst.
    run(3000, 70, 60, 20, 3, 3, 1, 5, 70);
    run(5, 100, 20, 0, 0, 0, 2, 4, 100);
    do_reset();
    run(300, 70, 60, 20, 3, 3, 1, 5, 70);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
